// File: rtl/data_sync_tx_pkg.sv
// Shared types and defaults for the toggle req/ack source-side synchronizer.
// Optional timeout monitor is enabled with DATA_SYNC_TX_TIMEOUT_EN.
package data_sync_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  localparam int C_DEF_NUM_SYNC = 5;
  localparam int C_DEF_TIMEOUT  = 1024;

  function automatic int wait_w(input int t);
    return (t > 2) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/data_sync_tx_if.sv
// Word handshake plus toggle req/ack bus between source and destination.
// slave = synchronizer side, master = producer/destination side.
interface data_sync_tx_if #(
  parameter int C_DATA_WIDTH = 64
);

  logic [C_DATA_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [C_DATA_WIDTH-1:0] xfer_data;
  logic                    xfer_req;
  logic                    xfer_ack;

  modport master (
    output s_data,
    output s_valid,
    output xfer_ack,
    input  s_ready,
    input  xfer_data,
    input  xfer_req
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  xfer_ack,
    output s_ready,
    output xfer_data,
    output xfer_req
  );

endinterface

// File: rtl/data_sync_tx_sync_chain_rst.sv
// Multi-flop synchronizer with async active-low reset to 0.
// Kept out of shift-register inference so each stage is a real flop.
module sync_chain_rst #(
  parameter int C_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
  logic [C_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[C_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[C_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source half of a two-phase req/ack bus synchronizer.
// Define DATA_SYNC_TX_TIMEOUT_EN to build the sticky WAIT_ACK timeout flag.
module data_sync_tx
  import data_sync_pkg::*;
#(
  parameter int C_DATA_WIDTH    = 64,
  parameter int C_NUM_SYNC_REGS = C_DEF_NUM_SYNC,
  parameter int C_CNT_WIDTH     = 16,
  parameter int C_TIMEOUT       = C_DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   resetn,
  data_sync_tx_if.slave          bus,
  output logic                   done,
  output logic [C_CNT_WIDTH-1:0] xfer_count,
  output logic                   err,
  input  logic                   err_clr
);

  state_t                  r_state;
  logic [C_DATA_WIDTH-1:0] r_data;
  logic                    r_req;
  logic                    r_done;
  logic [C_CNT_WIDTH-1:0]  r_count;
  logic                    w_ack_s;

  sync_chain_rst #(
    .C_STAGES (C_NUM_SYNC_REGS)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (resetn),
    .i_d   (bus.xfer_ack),
    .o_q   (w_ack_s)
  );

  // Data and toggle move on the same edge so the word is stable before req flips.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (1'b1)
        (r_state == IDLE): begin
          if (bus.s_valid) begin
            r_data  <= bus.s_data;
            r_req   <= ~r_req;
            r_state <= WAIT_ACK;
          end
        end
        (r_state == WAIT_ACK): begin
          if (w_ack_s == r_req) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready   = (r_state == IDLE);
  assign bus.xfer_data = r_data;
  assign bus.xfer_req  = r_req;
  assign done          = r_done;
  assign xfer_count    = r_count;

`ifdef DATA_SYNC_TX_TIMEOUT_EN
  localparam int C_WAIT_W = wait_w(C_TIMEOUT);
  localparam logic [C_WAIT_W-1:0] C_WAIT_MAX = C_WAIT_W'(C_TIMEOUT - 1);

  logic [C_WAIT_W-1:0] r_wait;
  logic                r_err;
  logic                w_to_hit;

  assign w_to_hit = (r_state == WAIT_ACK) && (r_wait == C_WAIT_MAX);

  // Counter restarts after each hit so err re-arms after a clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == IDLE) || w_to_hit) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_to_hit) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign err = r_err;
`else
  localparam int C_UNUSED_TIMEOUT = C_TIMEOUT;
  logic w_unused_clr;
  assign w_unused_clr = err_clr;
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx: table-driven transfers plus corner sequences.
// Timeout checks are built only with DATA_SYNC_TX_TIMEOUT_EN.
module tb_data_sync_tx;

  localparam int NS = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  data_sync_tx_if #(.C_DATA_WIDTH(64)) m ();
  logic        done;
  logic [15:0] cnt;
  logic        err;
  logic        err_clr = 1'b0;

  data_sync_tx #(
    .C_DATA_WIDTH    (64),
    .C_NUM_SYNC_REGS (NS),
    .C_CNT_WIDTH     (16),
    .C_TIMEOUT       (16)
  ) u_dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (m),
    .done       (done),
    .xfer_count (cnt),
    .err        (err),
    .err_clr    (err_clr)
  );

  data_sync_tx_if #(.C_DATA_WIDTH(8)) w ();
  logic       w_done;
  logic [3:0] w_cnt;
  logic       w_err;

  data_sync_tx #(
    .C_DATA_WIDTH    (8),
    .C_NUM_SYNC_REGS (2),
    .C_CNT_WIDTH     (4),
    .C_TIMEOUT       (16)
  ) u_wrap (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (w),
    .done       (w_done),
    .xfer_count (w_cnt),
    .err        (w_err),
    .err_clr    (1'b0)
  );

  always @(negedge clk) w.xfer_ack = w.xfer_req;

  logic ack_man = 1'b0;
  logic ack_auto = 1'b0;
  logic auto_ack = 1'b0;
  assign m.xfer_ack = auto_ack ? ack_auto : ack_man;

  always @(negedge clk) begin
    if (auto_ack) begin
      if (ack_auto != m.xfer_req) ack_auto = m.xfer_req;
    end else begin
      ack_auto = ack_man;
    end
  end

  logic        mon_en = 1'b0;
  logic        last_req = 1'b0;
  logic [63:0] held = '0;
  logic [63:0] rxq[$];
  int          stab_bad = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      last_req = m.xfer_req;
    end else begin
      if (m.xfer_req != last_req) begin
        rxq.push_back(m.xfer_data);
        held     = m.xfer_data;
        last_req = m.xfer_req;
      end else if (!m.s_ready && m.xfer_data != held) begin
        stab_bad++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer1(input logic [63:0] d, input int dly,
                       input logic exp_req, input logic [15:0] exp_cnt);
    @(negedge clk);
    chk("ready_before", 64'(m.s_ready), 64'd1);
    m.s_data  = d;
    m.s_valid = 1'b1;
    @(negedge clk);
    m.s_valid = 1'b0;
    m.s_data  = ~d;
    chk("data_after_accept", m.xfer_data, d);
    chk("req_toggle", 64'(m.xfer_req), 64'(exp_req));
    chk("ready_low", 64'(m.s_ready), 64'd0);
    repeat (dly) @(negedge clk);
    chk("no_done_before_ack", 64'(done), 64'd0);
    ack_man = exp_req;
    repeat (NS) @(negedge clk);
    chk("done_not_early", 64'(done), 64'd0);
    chk("ready_not_early", 64'(m.s_ready), 64'd0);
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd1);
    chk("ready_back", 64'(m.s_ready), 64'd1);
    chk("count", 64'(cnt), 64'(exp_cnt));
    chk("data_held", m.xfer_data, d);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  typedef struct {
    logic [63:0] data;
    int          dly;
    logic        exp_req;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sp_done;
    int wd;
    bit ok;

    m.s_data  = '0;
    m.s_valid = 1'b0;
    w.s_data  = 8'h5A;
    w.s_valid = 1'b0;

    tbl[0] = '{64'hDEAD_BEEF_0123_4567, 3, 1'b1, 16'd1};
    tbl[1] = '{64'h0000_0000_0000_0000, 0, 1'b0, 16'd2};
    tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 7, 1'b1, 16'd3};

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(m.s_ready), 64'd1);
    chk("rst_req", 64'(m.xfer_req), 64'd0);
    chk("rst_data", m.xfer_data, 64'd0);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    for (int i = 0; i < 3; i++) begin
      xfer1(tbl[i].data, tbl[i].dly, tbl[i].exp_req, tbl[i].exp_cnt);
    end

    // spurious ack toggle while idle
    @(negedge clk);
    ack_man = 1'b0;
    sp_done = 0;
    repeat (NS + 3) begin
      @(negedge clk);
      if (done) sp_done++;
    end
    chk("spur_no_done", 64'(sp_done), 64'd0);
    chk("spur_ready", 64'(m.s_ready), 64'd1);
    chk("spur_count", 64'(cnt), 64'd3);
    m.s_data  = 64'h1234;
    m.s_valid = 1'b1;
    @(negedge clk);
    m.s_valid = 1'b0;
    chk("spur_req", 64'(m.xfer_req), 64'd0);
    chk("spur_busy", 64'(m.s_ready), 64'd0);
    @(negedge clk);
    chk("spur_resolve_done", 64'(done), 64'd1);
    chk("spur_resolve_cnt", 64'(cnt), 64'd4);

    // reset two cycles into WAIT_ACK
    @(negedge clk);
    m.s_data  = 64'hCAFE_F00D_0000_0001;
    m.s_valid = 1'b1;
    @(negedge clk);
    m.s_valid = 1'b0;
    chk("mid_req", 64'(m.xfer_req), 64'd1);
    repeat (2) @(posedge clk);
    #2;
    resetn  = 1'b0;
    ack_man = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(m.s_ready), 64'd1);
    chk("mid_rst_req", 64'(m.xfer_req), 64'd0);
    chk("mid_rst_data", m.xfer_data, 64'd0);
    chk("mid_rst_count", 64'(cnt), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    xfer1(64'h0BAD_F00D_1357_9BDF, 2, 1'b1, 16'd1);

    // back-to-back with s_valid held and auto ack
    @(negedge clk);
    resetn  = 1'b0;
    ack_man = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    rxq.delete();
    done_cnt = 0;
    stab_bad = 0;
    mon_en   = 1'b1;
    auto_ack = 1'b1;
    m.s_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      m.s_data = 64'(i);
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
        if (m.s_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!ok) chk("b2b_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
    end
    m.s_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (cnt == 16'd4 && m.s_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("b2b_done_cnt", 64'(done_cnt), 64'd4);
    chk("b2b_rx_size", 64'(rxq.size()), 64'd4);
    for (int i = 0; i < rxq.size() && i < 4; i++) begin
      chk("b2b_word_order", rxq[i], 64'(i + 1));
    end
    chk("b2b_req_end", 64'(m.xfer_req), 64'd0);
    chk("b2b_count", 64'(cnt), 64'd4);
    chk("b2b_data_stable", 64'(stab_bad), 64'd0);
    mon_en   = 1'b0;
    auto_ack = 1'b0;
    ack_man  = m.xfer_req;

`ifdef DATA_SYNC_TX_TIMEOUT_EN
    @(negedge clk);
    chk("to_err_idle", 64'(err), 64'd0);
    m.s_data  = 64'h7777;
    m.s_valid = 1'b1;
    @(negedge clk);
    m.s_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("to_err_not_yet", 64'(err), 64'd0);
    @(negedge clk);
    chk("to_err_set", 64'(err), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_err_cleared", 64'(err), 64'd0);
    repeat (14) @(negedge clk);
    chk("to_err_rearm_not_yet", 64'(err), 64'd0);
    @(negedge clk);
    chk("to_err_reset", 64'(err), 64'd1);
    ack_man = 1'b1;
    repeat (NS) @(negedge clk);
    @(negedge clk);
    chk("to_late_done", 64'(done), 64'd1);
    chk("to_late_count", 64'(cnt), 64'd5);
    chk("to_err_sticky", 64'(err), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
`else
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("no_to_err_zero", 64'(err), 64'd0);
`endif

    // counter wrap on a 4-bit count instance
    w.s_valid = 1'b1;
    wd = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (w_done) begin
        wd++;
        if (wd == 15) chk("wrap_pre", 64'(w_cnt), 64'd15);
        if (wd == 16) begin
          chk("wrap_zero", 64'(w_cnt), 64'd0);
          break;
        end
      end
    end
    if (wd < 16) chk("wrap_timeout", 64'(wd), 64'd16);
    w.s_valid = 1'b0;
    chk("wrap_err_zero", 64'(w_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
